// File: rtl/inst_pkg.sv
// Instruction field layout shared by the encoder/writer and the decoder.
package inst_pkg;
  localparam int COND_W = 2;
  localparam int OPCD_W = 4;
  localparam int REG_W  = 3;
  localparam int SRC2_W = 4;
  localparam int INST_W = 16;

  localparam int COND_LSB = 14;
  localparam int OPCD_LSB = 10;
  localparam int DEST_LSB = 7;
  localparam int SRC_LSB  = 4;
  localparam int SRC2_LSB = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

  typedef struct packed {
    logic [COND_W-1:0] cond;
    logic [OPCD_W-1:0] opcd;
    logic [REG_W-1:0]  dest;
    logic [REG_W-1:0]  source;
    logic [SRC2_W-1:0] source2;
  } inst_fields_t;

  function automatic logic [INST_W-1:0] pack_inst(input inst_fields_t f);
    logic [INST_W-1:0] w;
    w = '0;
    w[COND_LSB +: COND_W] = f.cond;
    w[OPCD_LSB +: OPCD_W] = f.opcd;
    w[DEST_LSB +: REG_W]  = f.dest;
    w[SRC_LSB  +: REG_W]  = f.source;
    w[SRC2_LSB +: SRC2_W] = f.source2;
    return w;
  endfunction
endpackage

// File: rtl/inst_fifo.sv
// Small synchronous FIFO; head is the registered oldest entry, valid when !empty.
module inst_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp];

  // Storage is not reset; occupancy is tracked by cnt alone.
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/inst_encoder_writer.sv
// Packs instruction fields into 16-bit words and streams them into instruction
// memory from a programmable base address, through a small FIFO.
module inst_encoder_writer
  import inst_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [COND_W-1:0] cond,
  input  logic [OPCD_W-1:0] opcd,
  input  logic [REG_W-1:0]  dest,
  input  logic [REG_W-1:0]  source,
  input  logic [SRC2_W-1:0] source2,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INST_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   wcnt;
  logic              ovf;
  logic              full, empty, push, pop;
  logic [INST_W-1:0] head;
  inst_fields_t      fld;

  assign fld  = '{cond: cond, opcd: opcd, dest: dest, source: source, source2: source2};
  assign push = in_valid && in_ready;
  assign pop  = mem_we && mem_ready;

  assign in_ready   = (state == ST_LOAD) && !full;
  assign mem_we     = ((state == ST_LOAD) || (state == ST_DRAIN)) && !empty;
  assign mem_addr   = addr;
  // Head is masked so the write data bus reads 0 whenever no write is offered.
  assign mem_wdata  = mem_we ? head : '0;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign overflow   = ovf;
  assign word_count = wcnt;

  inst_fifo #(.WIDTH(INST_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pack_inst(fld)),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      addr  <= '0;
      wcnt  <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          addr  <= base_addr;
          wcnt  <= '0;
          ovf   <= 1'b0;
          state <= ST_LOAD;
        end
        ST_LOAD:  if (push && in_last) state <= ST_DRAIN;
        ST_DRAIN: if (empty) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
      // pop is only possible in LOAD/DRAIN, so it never collides with the IDLE capture.
      if (pop) begin
        addr <= addr + 1'b1;
        if (&addr) ovf <= 1'b1;
        if (wcnt != '1) wcnt <= wcnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/inst_encoder_writer.md
Name: inst_encoder_writer

Overview:
Reverse of the instruction decode path. Accepts instruction fields (cond, opcd, dest, source, source2) over a valid/ready handshake and packs each set into a 16-bit instruction word. Buffers the words in a small FIFO and writes them sequentially into instruction memory, starting at a programmable base address. Sits between the test/boot loader and the instruction memory write port, so programs can be loaded without hand-assembling binary.

Parameters:
ADDR_W, 8, instruction memory address width; the address wraps at 2^ADDR_W.
FIFO_DEPTH, 4, number of packed words buffered; must be a power of 2 and at least 2.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  begin a load session; sampled only in IDLE
base_addr  input  ADDR_W  first write address, captured on start
in_valid  input  1  field set valid
in_ready  output  1  block can accept a field set
in_last  input  1  qualifies the final field set of the program
cond  input  2  condition field, packed to bits [15:14]
opcd  input  4  opcode, packed to bits [13:10]
dest  input  3  destination register, packed to bits [9:7]
source  input  3  source register, packed to bits [6:4]
source2  input  4  second source / shift field, packed to bits [3:0]
mem_we  output  1  memory write strobe
mem_addr  output  ADDR_W  write address
mem_wdata  output  16  packed instruction
mem_ready  input  1  memory accepts a write this cycle
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when the session completes
overflow  output  1  sticky; address wrapped during the session
word_count  output  ADDR_W+1  words written this session; saturates at its maximum value

Behaviour:
- Reset (asynchronous, takes effect immediately) forces the following:
  - state returns to IDLE and the FIFO is emptied;
  - in_ready, mem_we, busy, done and overflow go to 0;
  - mem_addr, mem_wdata and word_count go to 0.
  - Words in flight are discarded.
- Packing is pure concatenation {cond, opcd, dest, source, source2}, 16 bits. Every field value is legal.
- States are IDLE, LOAD, DRAIN and DONE.
  - IDLE: in_ready=0. On start=1, capture base_addr into the address counter, clear word_count and overflow, then go to LOAD.
  - LOAD: in_ready = !fifo_full. A transfer occurs when in_valid && in_ready, and the packed word is pushed. A transfer with in_last=1 moves the block to DRAIN. While in_valid=0, the block stays in LOAD.
  - DRAIN: in_ready=0. When the FIFO is empty and no write is pending, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored outside IDLE.
- Write side:
  - mem_we = !fifo_empty in LOAD or DRAIN.
  - mem_wdata is the FIFO head; mem_addr is the address counter.
  - A write completes when mem_we && mem_ready. On completion: pop the FIFO, increment the address by 1, and increment word_count.
  - mem_addr and mem_wdata stay stable while mem_we=1 and mem_ready=0.
- Latency: a word accepted in cycle N is presented with mem_we=1 in cycle N+1 at the earliest. There is no bypass around the FIFO.
- Full FIFO: in_ready=0. A push and a pop in the same cycle are permitted when the FIFO is not full. The count is then unchanged.
- Address wrap: incrementing from 2^ADDR_W-1 gives 0 and sets overflow. Overflow stays set until the next start or rst. Writes continue after the wrap.
- in_last on an empty program is not possible, because a session always carries at least one word.

Decomposition:
- Shared package (inst_pkg):
  - field widths: COND_W=2, OPCD_W=4, REG_W=3, SRC2_W=4, INST_W=16;
  - field LSB positions: 14, 10, 7, 4, 0;
  - state enum for IDLE, LOAD, DRAIN, DONE.
  - The existing decoder uses the same field constants.
- One sub-module, inst_fifo: a synchronous FIFO (WIDTH=16, DEPTH=FIFO_DEPTH) with push, pop, full, empty and head outputs.

Test Plan:
- Single word: start with base_addr=0x10, then send cond=0, opcd=1, dest=1, source=2, source2=0, last=1 (mem_ready=1). Required response: mem_we at addr 0x10 with data 0x04A0, then done pulses, word_count=1, busy=0.
- Three-word burst from base 0: send (0,1,1,2,0), (0,2,1,2,0), (0,3,2,1,0). Required response: writes 0x04A0@0, 0x08A0@1, 0x0D10@2, then a single done pulse.
- Back-pressure: hold mem_ready=0 and send 6 words. Required response: in_ready drops after 4 accepts, and mem_addr/mem_wdata stay stable. Release mem_ready: all 6 words are written in order with no loss.
- Wrap: base_addr=0xFF, 2 words. Required response: writes at 0xFF then 0x00, overflow=1, word_count=2.
- Reset mid-session: assert rst during DRAIN with 2 words queued. Required response: mem_we=0 in the same cycle; after release, busy=0 and no further writes occur until start.
- Start while busy: pulse start in LOAD with a new base_addr. Required response: the pulse is ignored and addresses continue from the original base.
